// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid buffer between a valid/ready writer and reader.
// main drives out_data; skid catches the word accepted while the reader stalls.
// in_ready is registered, so it has no combinational path from out_ready.
module pipe_skid_reg #(
   parameter int WIDTH = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] main_q, main_nxt;
   logic [WIDTH-1:0] skid_q, skid_nxt;
   logic             rdy_q, rdy_nxt;
   logic             in_fire, out_fire;

   assign in_fire  = in_valid & rdy_q;
   assign out_fire = out_valid & out_ready;
   assign in_ready = rdy_q;
   assign out_data = main_q;

   // State and data registers; reset clears everything and reopens the input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
         rdy_q  <= 1'b1;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
         rdy_q  <= rdy_nxt;
      end
   end

   // Next-state and register loads; in_ready is precomputed from the next state.
   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               main_nxt  = in_data;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (in_fire && out_fire) begin
               main_nxt = in_data;
            end else if (in_fire) begin
               skid_nxt  = in_data;
               state_nxt = FULL;
            end else if (out_fire) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               main_nxt  = skid_q;
               state_nxt = BUSY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      rdy_nxt = (state_nxt != FULL);
   end

   // Status outputs decoded from the state.
   always_comb begin
      out_valid = 1'b0;
      occupancy = 2'd0;
      case (state)
         BUSY: begin
            out_valid = 1'b1;
            occupancy = 2'd1;
         end
         FULL: begin
            out_valid = 1'b1;
            occupancy = 2'd2;
         end
         default: begin
            out_valid = 1'b0;
            occupancy = 2'd0;
         end
      endcase
   end

endmodule
